// File: rtl/ppu_pkg.sv
// ppu_pkg: shared pipeline-control types and constants.
// Holds the hazard FSM state encoding, the forwarding-select codes and the
// default register-specifier width used by hazard_ctrl and fwd_unit.
package ppu_pkg;
    localparam int REG_AW_DEF = 4;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        LU_STALL = 3'd1,
        FLUSH    = 3'd2,
        MEM_WAIT = 3'd3,
        ERR      = 3'd4
    } state_t;
endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: operand forwarding select for one ID-stage source.
// Ports: rs/use_rs (source register and its valid qualifier), ex_rd/ex_wr/ex_load
// (EX destination), mem_rd/mem_wr (MEM destination), sel (00 regfile, 01 EX, 10 MEM).
// A load in EX has no result yet, so it never forwards; the younger EX match wins.
module fwd_unit
    import ppu_pkg::*;
#(
    parameter int AW = REG_AW_DEF
) (
    input  logic [AW-1:0] rs,
    input  logic          use_rs,
    input  logic [AW-1:0] ex_rd,
    input  logic          ex_wr,
    input  logic          ex_load,
    input  logic [AW-1:0] mem_rd,
    input  logic          mem_wr,
    output logic [1:0]    sel
);
    assign sel = (use_rs & ex_wr & !ex_load & (rs == ex_rd)) ? FWD_EX  :
                 (use_rs & mem_wr & (rs == mem_rd))          ? FWD_MEM : FWD_REG;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller (stalls, flushes, memory wait, forwarding).
// Ports: clk, Reset (async active-low); id_rn/id_rm + id_use_rn/id_use_rm (ID sources);
// ex_rd/ex_wr/ex_load (EX dest); mem_rd/mem_wr (MEM dest); br_taken, mem_req, mem_ready;
// outputs pc_en/ifid_en/idex_en/exmem_en, ifid_flush/idex_flush, fwd_a/fwd_b, timeout_err.
// Build option HAZARD_FWD_EN: when defined, forwarding is active and only load-use stalls;
// otherwise fwd_a/fwd_b are 00 and any EX/MEM dependency stalls.
module hazard_ctrl
    import ppu_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [REG_AW-1:0] id_rn,
    input  logic [REG_AW-1:0] id_rm,
    input  logic              id_use_rn,
    input  logic              id_use_rm,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_wr,
    input  logic              ex_load,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_wr,
    input  logic              br_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              timeout_err
);
    localparam int CW = $clog2(WAIT_MAX + 1);

    state_t        state, state_nx;
    logic [CW-1:0] wait_cnt, wait_cnt_nx;
    logic [3:0]    en;
    logic          ifid_fl, idex_fl;
    logic          load_use, stall;

    assign load_use = ex_load & ex_wr & ((id_use_rn & (id_rn == ex_rd)) |
                                         (id_use_rm & (id_rm == ex_rd)));

`ifdef HAZARD_FWD_EN
    logic [1:0] sel_a, sel_b;

    fwd_unit #(.AW(REG_AW)) u_fwd_a (
        .rs(id_rn), .use_rs(id_use_rn), .ex_rd(ex_rd), .ex_wr(ex_wr),
        .ex_load(ex_load), .mem_rd(mem_rd), .mem_wr(mem_wr), .sel(sel_a)
    );
    fwd_unit #(.AW(REG_AW)) u_fwd_b (
        .rs(id_rm), .use_rs(id_use_rm), .ex_rd(ex_rd), .ex_wr(ex_wr),
        .ex_load(ex_load), .mem_rd(mem_rd), .mem_wr(mem_wr), .sel(sel_b)
    );

    assign stall = load_use;
    assign fwd_a = Reset ? sel_a : FWD_REG;
    assign fwd_b = Reset ? sel_b : FWD_REG;
`else
    logic raw_hit;

    // With no bypass network every in-flight producer of a source must drain first.
    assign raw_hit = (id_use_rn & ((ex_wr & (id_rn == ex_rd)) | (mem_wr & (id_rn == mem_rd)))) |
                     (id_use_rm & ((ex_wr & (id_rm == ex_rd)) | (mem_wr & (id_rm == mem_rd))));
    assign stall   = load_use | raw_hit;
    assign fwd_a   = FWD_REG;
    assign fwd_b   = FWD_REG;
`endif

    // LU_STALL and FLUSH last one cycle and decode exactly like RUN.
    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        en          = 4'b1111;
        ifid_fl     = 1'b0;
        idex_fl     = 1'b0;
        case (state)
            MEM_WAIT: begin
                en          = {4{mem_ready}};
                wait_cnt_nx = (wait_cnt == CW'(WAIT_MAX)) ? wait_cnt : wait_cnt + 1'b1;
                state_nx    = mem_ready ? RUN : (wait_cnt == CW'(WAIT_MAX)) ? ERR : MEM_WAIT;
            end
            ERR: en = 4'b0000;
            default: begin
                if (mem_req & !mem_ready) begin
                    en          = 4'b0000;
                    wait_cnt_nx = '0;
                    state_nx    = MEM_WAIT;
                end else if (br_taken) begin
                    ifid_fl  = 1'b1;
                    idex_fl  = 1'b1;
                    state_nx = FLUSH;
                end else if (stall) begin
                    en       = 4'b0011;
                    idex_fl  = 1'b1;
                    state_nx = LU_STALL;
                end else begin
                    state_nx = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            wait_cnt    <= wait_cnt_nx;
            timeout_err <= timeout_err | (state_nx == ERR);
        end
    end

    // Outputs are forced to their idle values while reset is held, regardless of inputs.
    assign pc_en      = !Reset | en[3];
    assign ifid_en    = !Reset | en[2];
    assign idex_en    = !Reset | en[1];
    assign exmem_en   = !Reset | en[0];
    assign ifid_flush = Reset & ifid_fl;
    assign idex_flush = Reset & idex_fl;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       Reset;
    logic [3:0] id_rn, id_rm, ex_rd, mem_rd;
    logic       id_use_rn, id_use_rm, ex_wr, ex_load, mem_wr, br_taken, mem_req, mem_ready;
    logic       pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, timeout_err;
    logic [1:0] fwd_a, fwd_b;
    logic [5:0] ctrl;
    int         tests = 0;
    int         fails = 0;

    localparam logic [5:0] IDLE  = 6'b111100;
    localparam logic [5:0] STALL = 6'b001101;
    localparam logic [5:0] FLSH  = 6'b111111;
    localparam logic [5:0] FRZ   = 6'b000000;

    hazard_ctrl #(.REG_AW(4), .WAIT_MAX(15)) dut (
        .clk(clk), .Reset(Reset),
        .id_rn(id_rn), .id_rm(id_rm), .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
        .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_load(ex_load),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    assign ctrl = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rn = '0; id_rm = '0; ex_rd = '0; mem_rd = '0;
        id_use_rn = 0; id_use_rm = 0; ex_wr = 0; ex_load = 0; mem_wr = 0;
        br_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic load_use_in();
        ex_load = 1; ex_wr = 1; ex_rd = 4'd3; id_rn = 4'd3; id_use_rn = 1;
    endtask

    initial begin
        idle();
        Reset = 0;
        load_use_in();
        br_taken = 1;
        #3;
        chk("rst_ctrl", 32'(ctrl), 32'(IDLE));
        chk("rst_fwd", 32'({fwd_a, fwd_b}), 0);
        chk("rst_terr", 32'(timeout_err), 0);
        idle();
        tick();
        Reset = 1;
        tick();
        chk("run_idle", 32'(ctrl), 32'(IDLE));

        load_use_in();
        #1;
        chk("lu_stall", 32'(ctrl), 32'(STALL));
        chk("lu_fwd_a", 32'(fwd_a), 0);
        tick();
        idle();
        #1;
        chk("lu_release", 32'(ctrl), 32'(IDLE));
        tick();

        load_use_in();
        br_taken = 1;
        #1;
        chk("br_lu_flush", 32'(ctrl), 32'(FLSH));
        tick();
        idle();
        #1;
        chk("br_after", 32'(ctrl), 32'(IDLE));
        tick();

        ex_wr = 1; ex_rd = 4'd5; mem_wr = 1; mem_rd = 4'd5; id_rm = 4'd5; id_use_rm = 1;
        id_rn = 4'd5; id_use_rn = 0;
        #1;
`ifdef HAZARD_FWD_EN
        chk("fwd_b_ex", 32'(fwd_b), 32'(2'b01));
        chk("fwd_ex_ctrl", 32'(ctrl), 32'(IDLE));
        chk("fwd_a_unq", 32'(fwd_a), 0);
        tick();
        ex_wr = 0;
        #1;
        chk("fwd_b_mem", 32'(fwd_b), 32'(2'b10));
        chk("fwd_mem_ctrl", 32'(ctrl), 32'(IDLE));
`else
        chk("nofwd_b", 32'(fwd_b), 0);
        chk("nofwd_stall_ex", 32'(ctrl), 32'(STALL));
        tick();
        #1;
        chk("nofwd_stall_rep", 32'(ctrl), 32'(STALL));
        tick();
        ex_wr = 0;
        #1;
        chk("nofwd_stall_mem", 32'(ctrl), 32'(STALL));
`endif
        tick();
        id_use_rm = 0;
        #1;
        chk("unq_fwd", 32'({fwd_a, fwd_b}), 0);
        chk("unq_ctrl", 32'(ctrl), 32'(IDLE));
        idle();
        tick();

        mem_req = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("memwait_frz", 32'(ctrl), 32'(FRZ));
            tick();
        end
        mem_ready = 1;
        #1;
        chk("memwait_go", 32'(ctrl), 32'(IDLE));
        chk("memwait_terr", 32'(timeout_err), 0);
        tick();
        idle();
        #1;
        chk("memwait_run", 32'(ctrl), 32'(IDLE));
        tick();

        mem_req = 1;
        for (int i = 0; i < 17; i++) begin
            #1;
            chk("to_frz", 32'(ctrl), 32'(FRZ));
            chk("to_terr_lo", 32'(timeout_err), 0);
            tick();
        end
        chk("to_terr_hi", 32'(timeout_err), 1);
        chk("err_frz", 32'(ctrl), 32'(FRZ));
        mem_ready = 1; br_taken = 1;
        tick();
        chk("err_sticky", 32'(timeout_err), 1);
        chk("err_noflush", 32'(ctrl), 32'(FRZ));
        idle();
        Reset = 0;
        #1;
        chk("err_rst_terr", 32'(timeout_err), 0);
        chk("err_rst_ctrl", 32'(ctrl), 32'(IDLE));
        tick();
        Reset = 1;
        br_taken = 1;
        #1;
        chk("err_rst_run", 32'(ctrl), 32'(FLSH));
        tick();
        idle();
        tick();

        mem_req = 1;
        tick();
        tick();
        Reset = 0;
        mem_req = 0;
        #1;
        chk("mw_rst_ctrl", 32'(ctrl), 32'(IDLE));
        chk("mw_rst_terr", 32'(timeout_err), 0);
        tick();
        Reset = 1;
        #1;
        chk("mw_rst_run", 32'(ctrl), 32'(IDLE));
        mem_req = 1;
        for (int i = 0; i < 17; i++) begin
            #1;
            chk("mw2_terr_lo", 32'(timeout_err), 0);
            tick();
        end
        chk("mw2_terr_hi", 32'(timeout_err), 1);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
